// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared types and helpers for the PISO transmit scheduler.
//   state_t  - scheduler FSM states (explicit legacy encoding)
//   rr_pick  - round-robin search: first set valid bit at or above ptr,
//              wrapping modulo n
//   CNT_W / ID_W - counter and grant-index widths for the default
//              configuration (4 requesters, 4-bit words)
package piso_tx_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int WIDTH_DEF      = 4;
  localparam int GAP_CYCLES_DEF = 1;

  localparam int CNT_W = $clog2(WIDTH_DEF);
  localparam int ID_W  = $clog2(N_REQ_DEF);

  // Widest requester vector rr_pick can search.
  localparam int RR_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Returns the first index with valid set, starting at ptr and wrapping
  // at n. Returns 0 when nothing is valid (callers gate on |valid).
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (!found && valid[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: WIDTH-bit parallel-load, MSB-first shift register.
//   clk, rst  - clock, synchronous active-high reset (clears the register)
//   load      - capture d_in (has priority over shift_en)
//   shift_en  - shift left by one, zero filled from the LSB
//   d_in      - parallel word to load
//   msb       - current most significant bit (the serial data bit)
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d_in,
  output logic             msb
);

  logic [WIDTH-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= d_in;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shift_reg[WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: round-robin arbiter feeding one shared PISO shifter.
// One word is accepted per frame (valid/ready), shifted out MSB first over
// WIDTH cycles, followed by GAP_CYCLES forced idle cycles.
//   clk, rst     - clock, synchronous active-high reset
//   req_valid    - per-requester word-available flags
//   req_data     - packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready    - one-hot accept strobe, combinational, only in IDLE
//   serial_out   - serial data, MSB first, 0 when no data bit is on the line
//   frame_active - high while serial_out carries a data bit
//   bit_last     - high during the final data bit of a frame
//   grant_id     - requester whose word is being shifted
//   busy         - high while shifting or in the idle gap
module piso_tx_scheduler
  import piso_tx_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     serial_out,
  output logic                     frame_active,
  output logic                     bit_last,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int ID_BITS  = $clog2(N_REQ);
  localparam int CNT_BITS = $clog2(WIDTH);
  localparam int GAP_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t              state;
  logic [CNT_BITS-1:0] bit_cnt;
  logic [GAP_BITS-1:0] gap_cnt;
  logic [ID_BITS-1:0]  rr_ptr;
  logic [ID_BITS-1:0]  pick;
  logic [ID_BITS-1:0]  rr_next;
  logic                any_valid;
  logic                accept;
  logic                last_bit;
  logic                gap_done;
  logic                shift_msb;

  assign any_valid = |req_valid;
  // No accept during the reset cycle so no ready pulse escapes a reset.
  assign accept    = (state == IDLE) && any_valid && !rst;
  assign last_bit  = (bit_cnt == CNT_BITS'(WIDTH - 1));
  assign gap_done  = (int'(gap_cnt) == GAP_CYCLES - 1);

  always_comb begin
    pick    = ID_BITS'(rr_pick(RR_MAX'(req_valid), int'(rr_ptr), N_REQ));
    rr_next = (int'(pick) + 1 == N_REQ) ? '0 : pick + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[pick] = 1'b1;
    end
  end

  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift_en (state == SHIFT),
    .d_in     (req_data[pick*WIDTH +: WIDTH]),
    .msb      (shift_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            rr_ptr   <= rr_next;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_done) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign frame_active = (state == SHIFT);
  assign serial_out   = frame_active && shift_msb;
  assign bit_last     = frame_active && last_bit;
  assign busy         = (state != IDLE);

endmodule

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
Shares one parallel-in/serial-out shifter among N_REQ requesters using a round-robin arbiter. The block accepts one parallel word per frame through a valid/ready handshake and shifts it out MSB-first on a single serial line. It inserts a programmable idle gap between frames. It sits between the parallel producers and the serial link, and it sequences the load and shift of the shift register.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 4, bits per word / frame length in cycles (>=2)
GAP_CYCLES, 1, idle cycles forced after each frame (>=0)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester word-available flag
req_data  input  N_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  N_REQ  one-hot accept strobe; combinational, asserted only in IDLE
serial_out  output  1  serial data, MSB first
frame_active  output  1  high while serial_out carries a data bit
bit_last  output  1  high during the final data bit of a frame
grant_id  output  $clog2(N_REQ)  index of the requester whose word is being shifted
busy  output  1  high in SHIFT or GAP

Behaviour:
- Reset and clock: rst (synchronous, active-high) and clk are the decided reset and clock.
- Reset state: state=IDLE, shift_reg=0, bit_cnt=0, gap_cnt=0, rr_ptr=0, grant_id=0.
- Outputs after reset: serial_out=0, frame_active=0, bit_last=0, busy=0, req_ready=0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If any req_valid is high, pick the first set index searching upward from rr_ptr, wrapping modulo N_REQ. Call it g.
  - req_ready[g]=1 in the same cycle. The handshake completes at that clock edge.
  - At that edge: shift_reg<=req_data[g], grant_id<=g, rr_ptr<=(g+1) mod N_REQ, bit_cnt<=0, state<=SHIFT.
  - If no req_valid is high, the block stays in IDLE with no state change.
- SHIFT:
  - serial_out=shift_reg[WIDTH-1] and frame_active=1.
  - Each cycle: shift_reg<={shift_reg[WIDTH-2:0],1'b0} and bit_cnt increments.
  - bit_last=1 when bit_cnt==WIDTH-1.
  - On that cycle: if GAP_CYCLES>0, state<=GAP with gap_cnt<=0; otherwise state<=IDLE.
- GAP:
  - serial_out=0, frame_active=0, busy=1.
  - After GAP_CYCLES cycles, state<=IDLE.
- Latency: handshake at edge T produces data bits on cycles T+1..T+WIDTH. The next accept is possible in cycle T+WIDTH+GAP_CYCLES+1.
- Frame period: WIDTH+GAP_CYCLES+1 cycles under continuous load.
- req_ready is always 0 outside IDLE, and never more than one bit is set.
- Requester rules:
  - Hold req_data stable while req_valid=1 and req_ready=0.
  - Deasserting req_valid before the handshake is legal; the request is then simply not considered.
- req_data changes after acceptance have no effect on the frame in flight.
- Simultaneous requests: round-robin only. No requester waits more than N_REQ-1 frames.
- Single requester: rr_ptr still advances; that requester is re-granted every frame.
- rr_ptr wrap: when g=N_REQ-1, rr_ptr becomes 0.
- Reset mid-frame:
  - The frame is aborted and all outputs return to reset values at the next edge.
  - No further bits are emitted and no req_ready pulse occurs in the reset cycle.
- Only the WIDTH bits shift out; zeros are shifted in behind them.

Decomposition:
- Package piso_tx_pkg holds:
  - state_t enum {IDLE, SHIFT, GAP};
  - function rr_pick(valid, ptr) returning the granted index;
  - localparams CNT_W=$clog2(WIDTH) and ID_W=$clog2(N_REQ), computed from the parameters.
- Sub-module piso_shift_core, parameterised on WIDTH:
  - inputs: clk, rst, load, shift_en, d_in;
  - output: msb;
  - load has priority over shift_en; the register holds when neither is asserted.
- The top level contains the FSM, counters and arbiter.

Test Plan (N_REQ=4, WIDTH=4, GAP_CYCLES=1):
- Single request, req_valid=0001, data0=4'b1011 -> req_ready=0001 for 1 cycle; serial_out=1,0,1,1 on the next 4 cycles with frame_active=1 and bit_last on the 4th; then 1 GAP cycle; busy=0 after.
- All four valid continuously, data 0xA,0x5,0xF,0x1 -> grant order 0,1,2,3,0; frames every 6 cycles; serial bits 1010,0101,1111,0001.
- rr_ptr=2 with valid=0011 -> grants requester 0 (wrap); rr_ptr then becomes 1.
- req_valid dropped before acceptance while busy -> no req_ready for that requester; other requesters are served normally.
- rst asserted on the 2nd bit of frame 0xC -> serial_out, frame_active and busy are 0 the next cycle; state IDLE; a fresh request restarts at rr_ptr=0.
- Change req_data of the granted requester during SHIFT -> emitted bits equal the value captured at the handshake.
